// File: rtl/mini_alu_core_rs_pkg.sv
// Shared MiniAlu definitions: opcode encodings and instruction field layout,
// used by every core and by the assembler/ROM generator.
package mini_alu_core_rs_pkg;

  localparam int OP_W = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_STO  = 4'd3,
    OP_BLE  = 4'd4,
    OP_JMP  = 4'd5,
    OP_CALL = 4'd6,
    OP_RET  = 4'd7,
    OP_LED  = 4'd8,
    OP_MUL  = 4'd9,
    OP_LCD  = 4'd10
  } opcode_e;

  // Instruction layout: {op, dst, src1, src0}, each field fw bits wide.
  function automatic int instr_w(input int fw);
    return OP_W + 3 * fw;
  endfunction

  function automatic int op_lsb(input int fw);
    return 3 * fw;
  endfunction

  function automatic int dst_lsb(input int fw);
    return 2 * fw;
  endfunction

  function automatic int src1_lsb(input int fw);
    return fw;
  endfunction

  function automatic int src0_lsb(input int fw);
    return 0 * fw;
  endfunction

endpackage

// File: rtl/mini_alu_core_rs_ret_stack.sv
// Return-address LIFO for CALL/RET. Push on full and pop on empty are ignored;
// the core decides what that means architecturally.
module mini_alu_ret_stack #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] depth
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [2**IW];
  logic [CW-1:0] top_ptr;

  assign full    = (depth == CW'(DEPTH));
  assign empty   = (depth == '0);
  assign top_ptr = depth - CW'(1);
  assign top     = mem[top_ptr[IW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      for (int i = 0; i < 2**IW; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[depth[IW-1:0]] <= push_data;
      depth              <= depth + CW'(1);
    end else if (pop && !empty) begin
      depth <= depth - CW'(1);
    end
  end

endmodule

// File: rtl/mini_alu_core_rs.sv
// MiniAlu two-stage core (fetch / execute) with a hardware return stack and
// an LCD output port that stalls the whole pipeline on back-pressure.
module mini_alu_core_rs
  import mini_alu_core_rs_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int FIELD_W  = 8,
  parameter  int IMEM_AW  = 16,
  parameter  int RF_AW    = 5,
  parameter  int RS_DEPTH = 4,
  parameter  int LED_W    = 8,
  localparam int INSTR_W  = instr_w(FIELD_W),
  localparam int SD_W     = $clog2(RS_DEPTH + 1)
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [IMEM_AW-1:0] oIP,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [LED_W-1:0]   oLed,
  output logic [7:0]         oLcdData,
  output logic               oLcdValid,
  input  logic               iLcdReady,
  output logic [SD_W-1:0]    oStackDepth,
  output logic               oStackErr
);

  localparam int OP_LSB   = op_lsb(FIELD_W);
  localparam int DST_LSB  = dst_lsb(FIELD_W);
  localparam int SRC1_LSB = src1_lsb(FIELD_W);
  localparam int SRC0_LSB = src0_lsb(FIELD_W);
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, (3 * FIELD_W)'(0)};

  logic [IMEM_AW-1:0] ip;
  logic [IMEM_AW-1:0] ir_pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  rf [2**RF_AW];

  opcode_e            op;
  logic [FIELD_W-1:0] dst;
  logic [FIELD_W-1:0] src1;
  logic [FIELD_W-1:0] src0;
  logic [DATA_W-1:0]  opa;
  logic [DATA_W-1:0]  opb;

  logic               rf_we;
  logic [DATA_W-1:0]  rf_wd;
  logic               led_we;
  logic               branch;
  logic [IMEM_AW-1:0] target;
  logic               rs_push;
  logic               rs_pop;
  logic               err_set;
  logic [IMEM_AW-1:0] rs_top;
  logic               rs_full;
  logic               rs_empty;
  logic               stall;
  logic               advance;

  assign op   = opcode_e'(ir[OP_LSB +: OP_W]);
  assign dst  = ir[DST_LSB  +: FIELD_W];
  assign src1 = ir[SRC1_LSB +: FIELD_W];
  assign src0 = ir[SRC0_LSB +: FIELD_W];
  assign opa  = rf[src1[RF_AW-1:0]];
  assign opb  = rf[src0[RF_AW-1:0]];
  assign oIP  = ip;

  // LCD handshake: oLcdValid/oLcdData come straight from IR, so they are
  // stable for as long as the LCD instruction is held. A byte transfers on a
  // rising edge with Valid & Ready; until then every piece of state holds.
  assign oLcdValid = (op == OP_LCD);
  assign oLcdData  = oLcdValid ? 8'(src1) : 8'h00;
  assign stall     = oLcdValid && !iLcdReady;
  assign advance   = !stall;

  always_comb begin
    rf_we   = 1'b0;
    rf_wd   = '0;
    led_we  = 1'b0;
    branch  = 1'b0;
    target  = '0;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    err_set = 1'b0;
    case (op)
      OP_ADD: begin
        rf_we = 1'b1;
        rf_wd = opa + opb;
      end
      OP_SUB: begin
        rf_we = 1'b1;
        rf_wd = opa - opb;
      end
      OP_MUL: begin
        rf_we = 1'b1;
        rf_wd = opa * opb;
      end
      OP_STO: begin
        rf_we = 1'b1;
        rf_wd = DATA_W'({src1, src0});
      end
      OP_BLE: begin
        if (opa <= opb) begin
          branch = 1'b1;
          target = IMEM_AW'(dst);
        end
      end
      OP_JMP: begin
        branch = 1'b1;
        target = IMEM_AW'(dst);
      end
      OP_LED: led_we = 1'b1;
      // Stack overflow/underflow degrade to NOP and only raise the sticky flag.
      OP_CALL: begin
        if (rs_full) begin
          err_set = 1'b1;
        end else begin
          rs_push = 1'b1;
          branch  = 1'b1;
          target  = IMEM_AW'(dst);
        end
      end
      OP_RET: begin
        if (rs_empty) begin
          err_set = 1'b1;
        end else begin
          rs_pop = 1'b1;
          branch = 1'b1;
          target = rs_top;
        end
      end
      default: ;
    endcase
  end

  mini_alu_ret_stack #(
    .DEPTH (RS_DEPTH),
    .AW    (IMEM_AW)
  ) u_ret_stack (
    .clk       (Clock),
    .rst_n     (Reset),
    .push      (rs_push && advance),
    .pop       (rs_pop && advance),
    .push_data (ir_pc + IMEM_AW'(1)),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty),
    .depth     (oStackDepth)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ip        <= '0;
      ir        <= NOP_INSTR;
      ir_pc     <= '0;
      oLed      <= '0;
      oStackErr <= 1'b0;
    end else if (advance) begin
      if (branch) begin
        ip <= target;
        ir <= NOP_INSTR;
      end else begin
        ip <= ip + IMEM_AW'(1);
        ir <= iInstruction;
      end
      ir_pc <= ip;
      if (led_we)  oLed      <= LED_W'(opa);
      if (err_set) oStackErr <= 1'b1;
    end
  end

  // Written at the same edge the next instruction enters IR, so no forwarding.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 2**RF_AW; i++) rf[i] <= '0;
    end else if (advance && rf_we) begin
      rf[dst[RF_AW-1:0]] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mini_alu_core_rs.sv
// Directed-program bench for mini_alu_core_rs: per-test ROM images, expected
// LED/LCD/stack events queued up front and matched by an output monitor.
module tb_mini_alu_core_rs;
  import mini_alu_core_rs_pkg::*;

  localparam int IMEM_AW = 16;
  localparam int INSTR_W = 28;
  localparam int LED_W   = 16;
  localparam int SD_W    = 3;

  localparam logic [3:0] K_LED = 4'd1;
  localparam logic [3:0] K_LCD = 4'd2;
  localparam logic [3:0] K_DEP = 4'd3;
  localparam logic [3:0] K_ERR = 4'd4;

  logic               Clock = 1'b0;
  logic               Reset = 1'b0;
  logic               iLcdReady = 1'b1;
  logic [IMEM_AW-1:0] oIP;
  logic [INSTR_W-1:0] iInstruction;
  logic [LED_W-1:0]   oLed;
  logic [7:0]         oLcdData;
  logic               oLcdValid;
  logic [SD_W-1:0]    oStackDepth;
  logic               oStackErr;

  logic [INSTR_W-1:0] rom [256];
  logic [19:0]        exp_q [$];
  int                 checks = 0;
  int                 errors = 0;

  mini_alu_core_rs #(
    .DATA_W   (16),
    .FIELD_W  (8),
    .IMEM_AW  (IMEM_AW),
    .RF_AW    (5),
    .RS_DEPTH (4),
    .LED_W    (LED_W)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .oLed         (oLed),
    .oLcdData     (oLcdData),
    .oLcdValid    (oLcdValid),
    .iLcdReady    (iLcdReady),
    .oStackDepth  (oStackDepth),
    .oStackErr    (oStackErr)
  );

  assign iInstruction = rom[oIP[7:0]];

  // ---------------- clock / watchdog ----------------
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [INSTR_W-1:0] ins(input opcode_e op, input logic [7:0] d,
                                             input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [3:0] kind, input logic [15:0] val);
    exp_q.push_back({kind, val});
  endtask

  task automatic reset_hold();
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic end_test(input string name);
    run(4);
    check({name, " pending events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic observe(input logic [3:0] kind, input logic [15:0] val);
    logic [19:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d value 0x%0h required no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e !== {kind, val}) begin
        errors++;
        $display("FAIL event: got kind %0d value 0x%0h required kind %0d value 0x%0h",
                 kind, val, e[19:16], e[15:0]);
      end
    end
  endtask

  initial begin
    logic [LED_W-1:0] prev_led;
    logic [SD_W-1:0]  prev_dep;
    logic             prev_err;
    prev_led = '0;
    prev_dep = '0;
    prev_err = 1'b0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        if (oLed !== prev_led)       observe(K_LED, 16'(oLed));
        if (oStackDepth !== prev_dep) observe(K_DEP, 16'(oStackDepth));
        if (oStackErr && !prev_err)  observe(K_ERR, 16'd1);
        if (oLcdValid && iLcdReady)  observe(K_LCD, {8'h00, oLcdData});
      end
      prev_led = oLed;
      prev_dep = oStackDepth;
      prev_err = oStackErr;
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    // Test 1: reset state, then STO/STO/ADD/LED with timing
    reset_hold();
    check("reset oIP", 32'(oIP), 0);
    check("reset oLed", 32'(oLed), 0);
    check("reset oLcdValid", 32'(oLcdValid), 0);
    check("reset oLcdData", 32'(oLcdData), 0);
    check("reset oStackDepth", 32'(oStackDepth), 0);
    check("reset oStackErr", 32'(oStackErr), 0);
    rom[0] = ins(OP_STO, 8'd1, 8'h00, 8'h05);
    rom[1] = ins(OP_STO, 8'd2, 8'h00, 8'h03);
    rom[2] = ins(OP_ADD, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[4] = ins(OP_JMP, 8'd4, 8'd0, 8'd0);
    expect_ev(K_LED, 16'd8);
    Reset = 1'b1;
    run(4);
    check("t1 oLed before LED retires", 32'(oLed), 0);
    run(1);
    check("t1 oLed after LED retires", 32'(oLed), 8);
    end_test("t1");

    // Test 2: wrap-around arithmetic
    reset_hold();
    rom[0] = ins(OP_STO, 8'd1, 8'hFF, 8'hFF);
    rom[1] = ins(OP_STO, 8'd2, 8'h00, 8'h01);
    rom[2] = ins(OP_ADD, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(OP_SUB, 8'd4, 8'd2, 8'd1);
    rom[4] = ins(OP_MUL, 8'd5, 8'd1, 8'd1);
    rom[5] = ins(OP_LED, 8'd0, 8'd4, 8'd0);
    rom[6] = ins(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[7] = ins(OP_LED, 8'd0, 8'd5, 8'd0);
    rom[8] = ins(OP_JMP, 8'd8, 8'd0, 8'd0);
    expect_ev(K_LED, 16'h0002);
    expect_ev(K_LED, 16'h0000);
    expect_ev(K_LED, 16'h0001);
    Reset = 1'b1;
    run(12);
    end_test("t2");

    // Test 3: counted loop with BLE, one bubble per taken branch
    reset_hold();
    rom[0] = ins(OP_STO, 8'd1, 8'h00, 8'h00);
    rom[1] = ins(OP_STO, 8'd2, 8'h00, 8'h01);
    rom[2] = ins(OP_STO, 8'd3, 8'h00, 8'h04);
    rom[3] = ins(OP_ADD, 8'd1, 8'd1, 8'd2);
    rom[4] = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[5] = ins(OP_BLE, 8'd3, 8'd1, 8'd3);
    rom[6] = ins(OP_JMP, 8'd6, 8'd0, 8'd0);
    for (int k = 1; k <= 5; k++) expect_ev(K_LED, 16'(k));
    Reset = 1'b1;
    run(21);
    check("t3 oLed after 4 iterations", 32'(oLed), 4);
    run(1);
    check("t3 oLed after 5th iteration", 32'(oLed), 5);
    run(10);
    end_test("t3");

    // Test 4: nested CALL x4 then RET x4
    reset_hold();
    rom[0] = ins(OP_CALL, 8'd10, 8'd0, 8'd0);
    rom[1] = ins(OP_STO, 8'd1, 8'h00, 8'h01);
    rom[2] = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[3] = ins(OP_JMP, 8'd3, 8'd0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      rom[10*k]     = ins(OP_CALL, 8'(10*(k+1)), 8'd0, 8'd0);
      rom[10*k + 1] = ins(OP_STO, 8'd1, 8'h00, 8'(k+1));
      rom[10*k + 2] = ins(OP_LED, 8'd0, 8'd1, 8'd0);
      rom[10*k + 3] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    end
    rom[40] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    expect_ev(K_DEP, 16'd1);
    expect_ev(K_DEP, 16'd2);
    expect_ev(K_DEP, 16'd3);
    expect_ev(K_DEP, 16'd4);
    expect_ev(K_DEP, 16'd3);
    expect_ev(K_LED, 16'd4);
    expect_ev(K_DEP, 16'd2);
    expect_ev(K_LED, 16'd3);
    expect_ev(K_DEP, 16'd1);
    expect_ev(K_LED, 16'd2);
    expect_ev(K_DEP, 16'd0);
    expect_ev(K_LED, 16'd1);
    Reset = 1'b1;
    run(60);
    check("t4 oStackDepth at end", 32'(oStackDepth), 0);
    check("t4 oStackErr at end", 32'(oStackErr), 0);
    end_test("t4");

    // Test 5a: CALL on a full stack falls through and sets the sticky error
    reset_hold();
    for (int k = 0; k <= 3; k++) rom[10*k] = ins(OP_CALL, 8'(10*(k+1)), 8'd0, 8'd0);
    rom[40] = ins(OP_CALL, 8'd50, 8'd0, 8'd0);
    rom[41] = ins(OP_STO, 8'd1, 8'h00, 8'h55);
    rom[42] = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[43] = ins(OP_JMP, 8'd43, 8'd0, 8'd0);
    for (int k = 1; k <= 4; k++) expect_ev(K_DEP, 16'(k));
    expect_ev(K_ERR, 16'd1);
    expect_ev(K_LED, 16'h0055);
    Reset = 1'b1;
    run(40);
    check("t5a oStackDepth holds full", 32'(oStackDepth), 4);
    check("t5a oStackErr sticky", 32'(oStackErr), 1);
    end_test("t5a");

    // Test 5b: RET on an empty stack after a fresh reset
    reset_hold();
    check("t5b oStackErr cleared by reset", 32'(oStackErr), 0);
    rom[0] = ins(OP_RET, 8'd0, 8'd0, 8'd0);
    rom[1] = ins(OP_STO, 8'd1, 8'h00, 8'h66);
    rom[2] = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[3] = ins(OP_JMP, 8'd3, 8'd0, 8'd0);
    expect_ev(K_ERR, 16'd1);
    expect_ev(K_LED, 16'h0066);
    Reset = 1'b1;
    run(10);
    check("t5b oStackErr set", 32'(oStackErr), 1);
    check("t5b oStackDepth", 32'(oStackDepth), 0);
    end_test("t5b");

    // Test 6a: LCD byte held off by Ready for three cycles
    reset_hold();
    iLcdReady = 1'b0;
    rom[0] = ins(OP_LCD, 8'd0, 8'h41, 8'd0);
    rom[1] = ins(OP_STO, 8'd1, 8'h00, 8'h07);
    rom[2] = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[3] = ins(OP_JMP, 8'd3, 8'd0, 8'd0);
    expect_ev(K_LCD, 16'h0041);
    expect_ev(K_LED, 16'h0007);
    Reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      run(1);
      check($sformatf("t6a oIP frozen c%0d", c), 32'(oIP), 1);
      check($sformatf("t6a oLcdValid c%0d", c), 32'(oLcdValid), 1);
      check($sformatf("t6a oLcdData c%0d", c), 32'(oLcdData), 32'h41);
    end
    iLcdReady = 1'b1;
    run(1);
    check("t6a oLcdValid after transfer", 32'(oLcdValid), 0);
    check("t6a oIP advances after transfer", 32'(oIP), 2);
    run(6);
    end_test("t6a");

    // Test 6b: reset asserted in the middle of a stall
    reset_hold();
    iLcdReady = 1'b0;
    rom[0] = ins(OP_LCD, 8'd0, 8'h41, 8'd0);
    rom[1] = ins(OP_JMP, 8'd1, 8'd0, 8'd0);
    Reset = 1'b1;
    run(2);
    check("t6b oLcdValid while stalled", 32'(oLcdValid), 1);
    Reset = 1'b0;
    #1;
    check("t6b oLcdValid drops on reset", 32'(oLcdValid), 0);
    check("t6b oIP on reset", 32'(oIP), 0);
    check("t6b oLcdData on reset", 32'(oLcdData), 0);
    end_test("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
